// File: rtl/tx_frame_arb_pkg.sv
// rtl/tx_frame_arb_pkg.sv - state encoding and constants shared by tx_frame_arb
// Purpose: arbiter FSM encoding, port identifiers and minimum-frame padding constants.
// Ports: none (package).
package tx_frame_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2,
        ST_PAD   = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int          MIN_FRAME_BYTES = 60;
    localparam logic [15:0] PAD_LAST_KEEP   = 16'h0fff;
    // Beat that carries the final byte of a minimum-size frame.
    localparam logic [2:0]  PAD_LAST_BEAT   = 3'd3;
    // Beat index saturates here; any frame reaching it is already long enough.
    localparam logic [2:0]  BEAT_IDX_MAX    = 3'd4;

endpackage

// File: rtl/axis_skid_slice.sv
// rtl/axis_skid_slice.sv - two-entry registered skid slice for a stream payload
// Purpose: breaks every combinational path between the upstream and downstream sides.
// Ports: clk, rst_n (async active-low); s_tdata/s_tvalid/s_tready upstream;
//        m_tdata/m_tvalid/m_tready downstream. W is the payload width.
module axis_skid_slice #(
    parameter int W = 145
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);

    logic [W-1:0] skid_tdata;
    logic         skid_tvalid;

    // Ready depends only on the skid register, so upstream never sees m_tready.
    assign s_tready = !skid_tvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata     <= '0;
            m_tvalid    <= 1'b0;
            skid_tdata  <= '0;
            skid_tvalid <= 1'b0;
        end else if (m_tready || !m_tvalid) begin
            // Output register free: drain the skid entry first to keep order.
            if (skid_tvalid) begin
                m_tdata     <= skid_tdata;
                m_tvalid    <= 1'b1;
                skid_tvalid <= 1'b0;
            end else begin
                m_tvalid <= s_tvalid;
                if (s_tvalid) begin
                    m_tdata <= s_tdata;
                end
            end
        end else if (s_tvalid && !skid_tvalid) begin
            // Output stalled: park the beat that was accepted this cycle.
            skid_tdata  <= s_tdata;
            skid_tvalid <= 1'b1;
        end
    end

endmodule

// File: rtl/tx_frame_arb.sv
// rtl/tx_frame_arb.sv - frame-level 2:1 round-robin stream arbiter for the MAC TX path
// Purpose: forwards whole frames from port A (DoCE) or port B (bypass) without interleaving,
//          ties broken round-robin, output registered through axis_skid_slice.
// Ports: user_clk, reset_n (async active-low); s_a_* / s_b_* input streams; m_* output stream;
//        frm_cnt_a / frm_cnt_b frames accepted per port (wrapping).
// Option: TX_MIN_PAD_EN pads frames shorter than 60 bytes with zero bytes up to 60.
module tx_frame_arb
    import tx_frame_arb_pkg::*;
#(
    parameter  int DATA_W = 128,
    parameter  int CNT_W  = 32,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic              user_clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s_a_tdata,
    input  logic [KEEP_W-1:0] s_a_tkeep,
    input  logic              s_a_tvalid,
    input  logic              s_a_tlast,
    output logic              s_a_tready,
    input  logic [DATA_W-1:0] s_b_tdata,
    input  logic [KEEP_W-1:0] s_b_tkeep,
    input  logic              s_b_tvalid,
    input  logic              s_b_tlast,
    output logic              s_b_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic [CNT_W-1:0]  frm_cnt_a,
    output logic [CNT_W-1:0]  frm_cnt_b
);

    localparam int SLICE_W = DATA_W + KEEP_W + 1;

    state_t              state, next_state;
    logic                last_grant;
    logic                grant_b;
    logic [DATA_W-1:0]   sel_tdata, out_tdata;
    logic [KEEP_W-1:0]   sel_tkeep, out_tkeep;
    logic                sel_tvalid, sel_tlast, out_tlast;
    logic                slice_tvalid, slice_tready;
    logic                beat_hs;

    assign grant_b    = (state == ST_GNT_B);
    assign sel_tdata  = grant_b ? s_b_tdata  : s_a_tdata;
    assign sel_tkeep  = grant_b ? s_b_tkeep  : s_a_tkeep;
    assign sel_tvalid = grant_b ? s_b_tvalid : s_a_tvalid;
    assign sel_tlast  = grant_b ? s_b_tlast  : s_a_tlast;
    assign beat_hs    = slice_tvalid && slice_tready;

`ifdef TX_MIN_PAD_EN
    logic [2:0]        beat_idx;
    logic [15:0]       byte_cnt;
    logic [DATA_W-1:0] byte_mask;
    logic              pad_short;

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            byte_mask[i*8 +: 8] = {8{sel_tkeep[i]}};
        end
    end

    // Valid only on the tlast beat; earlier beats are always full.
    assign byte_cnt  = 16'(beat_idx) * 16'(KEEP_W) + 16'($countones(sel_tkeep));
    assign pad_short = (state == ST_GNT_A || state == ST_GNT_B) && sel_tlast
                       && (byte_cnt < 16'(MIN_FRAME_BYTES));

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_idx <= '0;
        end else if (beat_hs) begin
            if (next_state == ST_IDLE) begin
                beat_idx <= '0;
            end else if (beat_idx != BEAT_IDX_MAX) begin
                beat_idx <= beat_idx + 3'd1;
            end
        end
    end
`endif

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        s_a_tready   = 1'b0;
        s_b_tready   = 1'b0;
        slice_tvalid = 1'b0;
        out_tdata    = sel_tdata;
        out_tkeep    = sel_tkeep;
        out_tlast    = sel_tlast;
        case (state)
            ST_IDLE: begin
                // Tie goes to the port that did not win last time.
                if (s_a_tvalid && (!s_b_tvalid || last_grant == PORT_B)) begin
                    next_state = ST_GNT_A;
                end else if (s_b_tvalid) begin
                    next_state = ST_GNT_B;
                end
            end
            ST_GNT_A, ST_GNT_B: begin
                s_a_tready   = !grant_b && slice_tready;
                s_b_tready   = grant_b && slice_tready;
                slice_tvalid = sel_tvalid;
                if (sel_tvalid && slice_tready && sel_tlast) begin
                    next_state = ST_IDLE;
                end
`ifdef TX_MIN_PAD_EN
                if (pad_short) begin
                    out_tdata = sel_tdata & byte_mask;
                    if (beat_idx == PAD_LAST_BEAT) begin
                        out_tkeep = KEEP_W'(PAD_LAST_KEEP);
                    end else begin
                        // Frame continues as zero beats generated in PAD.
                        out_tkeep = '1;
                        out_tlast = 1'b0;
                        if (sel_tvalid && slice_tready) begin
                            next_state = ST_PAD;
                        end
                    end
                end
`endif
            end
`ifdef TX_MIN_PAD_EN
            ST_PAD: begin
                slice_tvalid = 1'b1;
                out_tdata    = '0;
                out_tkeep    = (beat_idx == PAD_LAST_BEAT) ? KEEP_W'(PAD_LAST_KEEP) : {KEEP_W{1'b1}};
                out_tlast    = (beat_idx == PAD_LAST_BEAT);
                if (slice_tready && beat_idx == PAD_LAST_BEAT) begin
                    next_state = ST_IDLE;
                end
            end
`endif
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= PORT_B;
            frm_cnt_a  <= '0;
            frm_cnt_b  <= '0;
        end else begin
            if (state == ST_IDLE && next_state == ST_GNT_A) begin
                last_grant <= PORT_A;
            end
            if (state == ST_IDLE && next_state == ST_GNT_B) begin
                last_grant <= PORT_B;
            end
            if (beat_hs && sel_tlast && state == ST_GNT_A) begin
                frm_cnt_a <= frm_cnt_a + CNT_W'(1);
            end
            if (beat_hs && sel_tlast && state == ST_GNT_B) begin
                frm_cnt_b <= frm_cnt_b + CNT_W'(1);
            end
        end
    end

    axis_skid_slice #(
        .W (SLICE_W)
    ) u_slice (
        .clk      (user_clk),
        .rst_n    (reset_n),
        .s_tdata  ({out_tdata, out_tkeep, out_tlast}),
        .s_tvalid (slice_tvalid),
        .s_tready (slice_tready),
        .m_tdata  ({m_tdata, m_tkeep, m_tlast}),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

endmodule
